rob_param: RTL and testbench
============================

# rob_param

Parametrised reorder buffer for the out-of-order RISC-V core, sitting between issue, the two CDB producers (ALU, LSB), the register file and the instruction fetcher.
- Retires one instruction per cycle in program order, signals store commit to the LSB and detects branch mispredictions at retirement.
- Successor to the fixed-size ROB, with:
  - configurable depth and CDB port count;
  - count-based full/empty that uses every slot;
  - two tag-indexed operand lookup ports so the RS can read results not yet committed.

## Interface
- DEPTH, 16: entry count; power of two, ≥ 2.
- TAG_W, $clog2(DEPTH): tag width.
- CDB_N, 2: number of writeback ports (port 0 = ALU, port 1 = LSB).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- issue_valid  in  1  allocate one entry this cycle.
- issue_kind  in  2  0 = reg-write, 1 = store, 2 = branch, 3 = reserved (treated as 0).
- issue_rd  in  5  destination register.
- issue_pc  in  32  instruction PC.
- issue_imm  in  32  branch offset.
- issue_predict  in  1  predicted taken.
- next_tag  out  TAG_W  tag the next issued instruction will receive (= tail).
- full  out  1  count == DEPTH.
- cdb_valid  in  CDB_N  per-port result valid.
- cdb_tag  in  CDB_N*TAG_W  packed tags.
- cdb_value  in  CDB_N*32  packed results; for branches, bit 0 = actual taken.
- qry_tag[0..1]  in  TAG_W  lookup tags.
- qry_ready[0..1]  out  1  entry holds its final value.
- qry_value[0..1]  out  32  that value.
- commit_valid  out  1  one-cycle pulse per retirement.
- commit_rd  out  5  retired destination register.
- commit_tag  out  TAG_W  retired tag.
- commit_value  out  32  retired value.
- commit_store  out  1  the retired entry is a store.
- head_tag  out  TAG_W  oldest live tag, used by the LSB.
- bp_upd_valid  out  1  branch retired.
- bp_upd_taken  out  1  actual outcome.
- bp_upd_pc  out  32  branch PC.
- flush  out  1  one-cycle misprediction rollback.
- flush_pc  out  32  restart PC.

## Operation
- Storage per entry: valid, ready, kind, rd, value, pc, predict, reset_pc.
- Pointers: head, tail (TAG_W bits, wrap modulo DEPTH) and count (TAG_W+1 bits). Empty = (count == 0).
- Issue is accepted when issue_valid && !full && !flush.
  - Entry written at tail; tail advances.
  - reset_pc = issue_pc + (issue_predict ? 4 : issue_imm), 32-bit wrap.
  - ready at issue = 1 for stores and for reg-writes with rd == 0; 0 otherwise. Branches are always 0 at issue.
- CDB: for each port with cdb_valid set and a valid target entry, write value and set ready. Writes to invalid entries are dropped. If two ports hit the same tag, the higher-index port wins.
- Commit: when the buffer is not empty and ready[head] is set:
  - register commit_* from the head entry and pulse commit_valid;
  - invalidate the head entry, advance head, decrement count.
  - A store also pulses commit_store.
  - A branch pulses bp_upd_valid, with bp_upd_taken = value[0] and bp_upd_pc = pc.
  - If value[0] != predict: flush = 1, flush_pc = reset_pc. At the same edge, head = tail = count = 0 and every valid bit is cleared; an issue sampled at that edge is discarded.
- Issue and commit in the same cycle leave count unchanged.
- While flush is high, issue and CDB inputs are ignored.
- Query: combinational. qry_ready = valid & ready at qry_tag; qry_value = the stored value. Both are 0 for an invalid entry.

## Timing
- Reset values: all outputs 0; head = tail = count = 0; all valid and ready bits 0. next_tag = 0.
- Issue to visible entry: one edge.
- CDB to ready: one edge. The earliest commit pulse is the cycle after the CDB write edge.
- Minimum issue-to-commit for an entry ready at issue: commit_valid is high two cycles after the issue cycle.
- commit_*, bp_upd_* and flush are registered single-cycle pulses, cleared every cycle they are not re-asserted.
- full and next_tag are combinational from registered state.
- An rst_n assertion mid-operation clears everything immediately, including in-flight pulses.

## Configuration
- ROB_CDB_BYPASS_EN defined: a query whose tag matches a same-cycle valid CDB write returns qry_ready = 1 and qry_value = the CDB value, with the higher port winning.
  - The head entry may also commit in the cycle its CDB write arrives, saving one cycle.
- ROB_CDB_BYPASS_EN undefined: queries and commit see registered state only.

## Test plan
- Fill: DEPTH = 4, issue 4 reg-writes with rd = 5 and no CDB.
  - Expect full = 1 after the 4th edge; a 5th issue is ignored and tail stays 0.
  - Then CDB tag 0 with value 0x11: expect commit_valid with commit_rd = 5 and commit_value = 0x11, then full = 0.
- Out-of-order completion: issue tags 0, 1, 2 and complete them in the order 2, 1, 0.
  - Expect commits in tag order 0, 1, 2 on consecutive cycles.
- Misprediction: issue a branch with pc = 0x100, imm = 0x20, predict = 0, plus two younger entries; CDB value 1 to the branch.
  - Expect bp_upd_taken = 1, flush = 1 and flush_pc = 0x120.
  - The next cycle, count = 0 and next_tag = 0.
- Store: issue a store; with no CDB activity, expect commit_store = 1 two cycles later and commit_valid = 1.
- Wrap-around and query, DEPTH = 4:
  - Issue and commit 6 entries.
  - Issue at tag 2, CDB value 0xABCD; expect qry_ready = 1 and qry_value = 0xABCD on the following cycle, or in the same cycle with ROB_CDB_BYPASS_EN.
- Reset mid-run: drop rst_n while 3 entries are live and commit_valid = 1.
  - Expect all outputs 0 immediately; after release the first issue gets tag 0.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order retirement, store commit, branch flush and
// two tag-indexed operand lookups. Optional macro ROB_CDB_BYPASS_EN forwards CDB results.
module rob_param #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [1:0]             issue_kind,
  input  logic [4:0]             issue_rd,
  input  logic [31:0]            issue_pc,
  input  logic [31:0]            issue_imm,
  input  logic                   issue_predict,
  output logic [TAG_W-1:0]       next_tag,
  output logic                   full,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*32-1:0]    cdb_value,
  input  logic [1:0][TAG_W-1:0]  qry_tag,
  output logic [1:0]             qry_ready,
  output logic [1:0][31:0]       qry_value,
  output logic                   commit_valid,
  output logic [4:0]             commit_rd,
  output logic [TAG_W-1:0]       commit_tag,
  output logic [31:0]            commit_value,
  output logic                   commit_store,
  output logic [TAG_W-1:0]       head_tag,
  output logic                   bp_upd_valid,
  output logic                   bp_upd_taken,
  output logic [31:0]            bp_upd_pc,
  output logic                   flush,
  output logic [31:0]            flush_pc
);

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  logic [DEPTH-1:0]        valid_q, valid_d, ready_q, ready_d;
  logic [DEPTH-1:0][1:0]   kind_q;
  logic [DEPTH-1:0][4:0]   rd_q;
  logic [DEPTH-1:0][31:0]  value_q, pc_q, reset_pc_q;
  logic [DEPTH-1:0]        predict_q;
  logic [TAG_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]          count_q, count_d;

  logic                    commit_valid_q, commit_store_q;
  logic [4:0]              commit_rd_q;
  logic [TAG_W-1:0]        commit_tag_q;
  logic [31:0]             commit_value_q;
  logic                    bp_upd_valid_q, bp_upd_taken_q;
  logic [31:0]             bp_upd_pc_q;
  logic                    flush_q;
  logic [31:0]             flush_pc_q;

  logic [DEPTH-1:0]        cdb_we;
  logic [DEPTH-1:0][31:0]  cdb_wd;
  logic                    issue_acc, issue_ready, head_hit, commit_en, mispredict;
  logic                    head_is_branch;
  logic [1:0]              issue_kind_n;
  logic [31:0]             head_value;

  assign full     = (count_q == (TAG_W+1)'(DEPTH));
  assign next_tag = tail_q;
  assign head_tag = head_q;

  assign issue_acc    = issue_valid && !full && !flush_q;
  assign issue_kind_n = (issue_kind == KIND_RSVD) ? KIND_REG : issue_kind;
  assign issue_ready  = (issue_kind_n == KIND_STORE) ||
                        ((issue_kind_n == KIND_REG) && (issue_rd == 5'd0));

  // Per-entry CDB write decode; later ports overwrite earlier ones on a shared tag.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cdb_we = '0;
    cdb_wd = '0;
    if (!flush_q) begin
      for (int p = 0; p < CDB_N; p++) begin
        if (cdb_valid[p] && valid_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
          cdb_we[cdb_tag[p*TAG_W +: TAG_W]] = 1'b1;
          cdb_wd[cdb_tag[p*TAG_W +: TAG_W]] = cdb_value[p*32 +: 32];
        end
      end
    end
  end

`ifdef ROB_CDB_BYPASS_EN
  assign head_hit = cdb_we[head_q];
`else
  assign head_hit = 1'b0;
`endif

  assign head_value     = head_hit ? cdb_wd[head_q] : value_q[head_q];
  assign head_is_branch = (kind_q[head_q] == KIND_BRANCH);
  assign commit_en      = (count_q != '0) && (ready_q[head_q] || head_hit);
  assign mispredict     = commit_en && head_is_branch && (head_value[0] != predict_q[head_q]);

  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q | cdb_we;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{TAG_W{1'b0}}, issue_acc} - {{TAG_W{1'b0}}, commit_en};
    if (issue_acc) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = issue_ready;
      tail_d          = tail_q + 1'b1;
    end
    if (commit_en) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // A mispredict discards every younger entry, including one issued this cycle.
    if (mispredict) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      commit_store_q <= 1'b0;
      bp_upd_valid_q <= 1'b0;
      bp_upd_taken_q <= 1'b0;
      bp_upd_pc_q    <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_en;
      commit_rd_q    <= commit_en ? rd_q[head_q] : '0;
      commit_tag_q   <= commit_en ? head_q : '0;
      commit_value_q <= commit_en ? head_value : '0;
      commit_store_q <= commit_en && (kind_q[head_q] == KIND_STORE);
      bp_upd_valid_q <= commit_en && head_is_branch;
      bp_upd_taken_q <= commit_en && head_is_branch && head_value[0];
      bp_upd_pc_q    <= (commit_en && head_is_branch) ? pc_q[head_q] : '0;
      flush_q        <= mispredict;
      flush_pc_q     <= mispredict ? reset_pc_q[head_q] : '0;
    end
  end

  // NOTE: payload storage has no reset; valid_q/ready_q gate every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_we[i]) value_q[i] <= cdb_wd[i];
    end
    if (issue_acc) begin
      kind_q[tail_q]     <= issue_kind_n;
      rd_q[tail_q]       <= issue_rd;
      pc_q[tail_q]       <= issue_pc;
      predict_q[tail_q]  <= issue_predict;
      reset_pc_q[tail_q] <= issue_pc + (issue_predict ? 32'd4 : issue_imm);
      value_q[tail_q]    <= '0;
    end
  end

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      qry_ready[q] = valid_q[qry_tag[q]] & ready_q[qry_tag[q]];
      qry_value[q] = valid_q[qry_tag[q]] ? value_q[qry_tag[q]] : '0;
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_we[qry_tag[q]]) begin
        qry_ready[q] = 1'b1;
        qry_value[q] = cdb_wd[qry_tag[q]];
      end
`endif
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_tag   = commit_tag_q;
  assign commit_value = commit_value_q;
  assign commit_store = commit_store_q;
  assign bp_upd_valid = bp_upd_valid_q;
  assign bp_upd_taken = bp_upd_taken_q;
  assign bp_upd_pc    = bp_upd_pc_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param (DEPTH = 4): directed scenarios plus random
// traffic compared against a queue-based program-order model.
module tb_rob_param;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int CDB_N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   iv, ipred;
  logic [1:0]             ikind;
  logic [4:0]             ird;
  logic [31:0]            ipc, iimm;
  logic [CDB_N-1:0]       cv;
  logic [CDB_N*TAG_W-1:0] ctag;
  logic [CDB_N*32-1:0]    cval;
  logic [1:0][TAG_W-1:0]  qt;

  logic [TAG_W-1:0] next_tag, commit_tag, head_tag;
  logic             full, commit_valid, commit_store, bp_upd_valid, bp_upd_taken, flush;
  logic [1:0]       qry_ready;
  logic [1:0][31:0] qry_value;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_value, bp_upd_pc, flush_pc;

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(iv), .issue_kind(ikind), .issue_rd(ird), .issue_pc(ipc),
    .issue_imm(iimm), .issue_predict(ipred),
    .next_tag(next_tag), .full(full),
    .cdb_valid(cv), .cdb_tag(ctag), .cdb_value(cval),
    .qry_tag(qt), .qry_ready(qry_ready), .qry_value(qry_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_value(commit_value), .commit_store(commit_store), .head_tag(head_tag),
    .bp_upd_valid(bp_upd_valid), .bp_upd_taken(bp_upd_taken), .bp_upd_pc(bp_upd_pc),
    .flush(flush), .flush_pc(flush_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: live entries kept oldest-first.
  typedef struct {
    int          tag;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc, rpc, val;
    bit          pred, rdy, hv;
  } ent_t;

  ent_t rob[$];
  int   m_head, m_tail;
  bit   e_cv, e_cs, e_bv, e_bt, e_fl, e_hv;
  logic [4:0]  e_rd;
  int   e_tag;
  logic [31:0] e_val, e_bpc, e_fpc;

  function automatic int find(input int tag);
    for (int i = 0; i < rob.size(); i++) if (rob[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic model_reset();
    rob.delete();
    m_head = 0; m_tail = 0;
    e_cv = 0; e_cs = 0; e_bv = 0; e_bt = 0; e_fl = 0; e_hv = 1;
    e_rd = 0; e_tag = 0; e_val = 0; e_bpc = 0; e_fpc = 0;
  endtask

  task automatic clear_inputs();
    iv = 0; ikind = 0; ird = 0; ipc = 0; iimm = 0; ipred = 0;
    cv = '0; ctag = '0; cval = '0; qt = '0;
  endtask

  task automatic check_outputs();
    int idx;
    bit er, cmpv;
    logic [31:0] ev;
    check("full", 32'(full), 32'(rob.size() == DEPTH));
    check("next_tag", 32'(next_tag), 32'(m_tail));
    check("head_tag", 32'(head_tag), 32'(m_head));
    check("commit_valid", 32'(commit_valid), 32'(e_cv));
    check("commit_rd", 32'(commit_rd), 32'(e_rd));
    check("commit_tag", 32'(commit_tag), 32'(e_tag));
    if (e_hv) check("commit_value", commit_value, e_val);
    check("commit_store", 32'(commit_store), 32'(e_cs));
    check("bp_upd_valid", 32'(bp_upd_valid), 32'(e_bv));
    check("bp_upd_taken", 32'(bp_upd_taken), 32'(e_bt));
    check("bp_upd_pc", bp_upd_pc, e_bpc);
    check("flush", 32'(flush), 32'(e_fl));
    check("flush_pc", flush_pc, e_fpc);
    for (int q = 0; q < 2; q++) begin
      idx = find(int'(qt[q]));
      er = 0; ev = 0; cmpv = 1;
      if (idx >= 0) begin
        er = rob[idx].rdy; ev = rob[idx].val; cmpv = rob[idx].hv;
      end
`ifdef ROB_CDB_BYPASS_EN
      if (!e_fl && idx >= 0)
        for (int p = 0; p < CDB_N; p++)
          if (cv[p] && ctag[p*TAG_W +: TAG_W] == qt[q]) begin
            er = 1; ev = cval[p*32 +: 32]; cmpv = 1;
          end
`endif
      check($sformatf("qry_ready%0d", q), 32'(qry_ready[q]), 32'(er));
      if (cmpv) check($sformatf("qry_value%0d", q), qry_value[q], ev);
    end
  endtask

  task automatic model_edge();
    bit fl, iss, do_c, misp, old_rdy, old_hv, c_hv;
    logic [31:0] old_val, c_val;
    logic [1:0] k;
    int idx;
    ent_t h, n;
    fl  = e_fl;
    iss = iv && (rob.size() != DEPTH) && !fl;
    old_rdy = 0; old_hv = 0; old_val = 0;
    if (rob.size() > 0) begin
      old_rdy = rob[0].rdy; old_hv = rob[0].hv; old_val = rob[0].val;
    end
    if (!fl)
      for (int p = 0; p < CDB_N; p++)
        if (cv[p]) begin
          idx = find(int'(ctag[p*TAG_W +: TAG_W]));
          if (idx >= 0) begin
            rob[idx].val = cval[p*32 +: 32]; rob[idx].rdy = 1; rob[idx].hv = 1;
          end
        end
    e_cv = 0; e_rd = 0; e_tag = 0; e_val = 0; e_hv = 1; e_cs = 0;
    e_bv = 0; e_bt = 0; e_bpc = 0; e_fl = 0; e_fpc = 0;
    do_c = 0; misp = 0; c_val = 0; c_hv = 0;
    if (rob.size() > 0) begin
`ifdef ROB_CDB_BYPASS_EN
      do_c = rob[0].rdy; c_val = rob[0].val; c_hv = rob[0].hv;
`else
      do_c = old_rdy; c_val = old_val; c_hv = old_hv;
`endif
    end
    if (do_c) begin
      h = rob.pop_front();
      e_cv = 1; e_rd = h.rd; e_tag = h.tag; e_val = c_val; e_hv = c_hv;
      e_cs = (h.kind == 2'd1);
      if (h.kind == 2'd2) begin
        e_bv = 1; e_bt = c_val[0]; e_bpc = h.pc;
        if (c_val[0] != h.pred) begin
          misp = 1; e_fl = 1; e_fpc = h.rpc;
        end
      end
      m_head = (m_head + 1) % DEPTH;
    end
    if (misp) begin
      rob.delete(); m_head = 0; m_tail = 0;
    end else if (iss) begin
      k = (ikind == 2'd3) ? 2'd0 : ikind;
      n.tag = m_tail; n.kind = k; n.rd = ird; n.pc = ipc; n.pred = ipred;
      n.rpc = ipc + (ipred ? 32'd4 : iimm);
      n.rdy = (k == 2'd1) || (k == 2'd0 && ird == 5'd0);
      n.val = 0; n.hv = 0;
      rob.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  // Inputs are set at posedge+1; outputs are compared at the falling edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_commit(input string name, input int budget);
    int k;
    k = 0;
    while (commit_valid !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check({name, "_commit_seen"}, 32'(commit_valid), 32'd1);
  endtask

  task automatic set_issue(input logic [1:0] kind, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    iv = 1; ikind = kind; ird = rd; ipc = pc; iimm = imm; ipred = pred;
  endtask

  task automatic set_cdb(input int p, input int tag, input logic [31:0] v);
    cv[p] = 1'b1;
    ctag[p*TAG_W +: TAG_W] = TAG_W'(tag);
    cval[p*32 +: 32] = v;
  endtask

  task automatic rand_inputs();
    int t, idx;
    logic [31:0] v;
    clear_inputs();
    iv    = ($urandom_range(0, 99) < 55);
    ikind = 2'($urandom_range(0, 3));
    ird   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    ipc   = $urandom & 32'hFFFF_FFFC;
    iimm  = $urandom;
    ipred = 1'($urandom_range(0, 1));
    for (int p = 0; p < CDB_N; p++)
      if ($urandom_range(0, 99) < 45) begin
        if (rob.size() > 0 && $urandom_range(0, 99) < 85)
          t = rob[$urandom_range(0, rob.size() - 1)].tag;
        else
          t = $urandom_range(0, DEPTH - 1);
        v = $urandom;
        idx = find(t);
        if (idx >= 0 && rob[idx].kind == 2'd2 && $urandom_range(0, 99) < 70) v[0] = rob[idx].pred;
        set_cdb(p, t, v);
      end
    if (cv == 2'b11 && $urandom_range(0, 99) < 25) ctag[TAG_W +: TAG_W] = ctag[0 +: TAG_W];
    for (int q = 0; q < 2; q++)
      qt[q] = (rob.size() > 0 && $urandom_range(0, 99) < 70)
              ? TAG_W'(rob[$urandom_range(0, rob.size() - 1)].tag)
              : TAG_W'($urandom_range(0, DEPTH - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    model_reset();
    do_reset();

    // Fill: four reg-writes, fifth issue refused, then retire tag 0.
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); set_issue(2'd0, 5'd5, 32'h40 + 32'(4 * i), 0, 0); step();
    end
    check("fill_full", 32'(full), 32'd1);
    clear_inputs(); set_issue(2'd0, 5'd5, 32'h50, 0, 0); step();
    check("fill_tail_stays", 32'(next_tag), 32'd0);
    clear_inputs(); set_cdb(0, 0, 32'h11); step();
    clear_inputs(); wait_commit("fill", 4);
    check("fill_commit_rd", 32'(commit_rd), 32'd5);
    check("fill_commit_value", commit_value, 32'h11);
    check("fill_not_full", 32'(full), 32'd0);

    // Out-of-order completion retires in tag order on consecutive cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); set_issue(2'd0, 5'(i + 1), 32'h200, 0, 0); step();
    end
    for (int i = 2; i >= 0; i--) begin
      clear_inputs(); set_cdb(i % CDB_N, i, 32'hA0 + 32'(i)); step();
    end
    clear_inputs(); wait_commit("ooo", 4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ooo_commit%0d_valid", i), 32'(commit_valid), 32'd1);
      check($sformatf("ooo_commit%0d_tag", i), 32'(commit_tag), 32'(i));
      check($sformatf("ooo_commit%0d_value", i), commit_value, 32'hA0 + 32'(i));
      if (i < 2) step();
    end

    // Misprediction: not-taken prediction, taken outcome.
    do_reset();
    clear_inputs(); set_issue(2'd2, 5'd0, 32'h100, 32'h20, 1'b0); step();
    clear_inputs(); set_issue(2'd0, 5'd1, 32'h104, 0, 0); step();
    clear_inputs(); set_issue(2'd0, 5'd2, 32'h108, 0, 0); step();
    clear_inputs(); set_cdb(1, 0, 32'h1); step();
    clear_inputs(); wait_commit("mp", 4);
    check("mp_bp_valid", 32'(bp_upd_valid), 32'd1);
    check("mp_bp_taken", 32'(bp_upd_taken), 32'd1);
    check("mp_bp_pc", bp_upd_pc, 32'h100);
    check("mp_flush", 32'(flush), 32'd1);
    check("mp_flush_pc", flush_pc, 32'h120);
    check("mp_next_tag", 32'(next_tag), 32'd0);
    set_issue(2'd0, 5'd3, 32'h120, 0, 0); step();
    check("mp_issue_ignored", 32'(next_tag), 32'd0);
    check("mp_flush_clear", 32'(flush), 32'd0);

    // Store is ready at issue and retires two cycles later.
    do_reset();
    clear_inputs(); set_issue(2'd1, 5'd7, 32'h300, 0, 0); step();
    clear_inputs(); step();
    check("store_commit_valid", 32'(commit_valid), 32'd1);
    check("store_commit_store", 32'(commit_store), 32'd1);

    // Wrap-around then query of tag 2.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clear_inputs(); set_issue(2'd0, 5'd0, 32'h400 + 32'(4 * i), 0, 0); step();
    end
    clear_inputs(); step();
    check("wrap_next_tag", 32'(next_tag), 32'd2);
    check("wrap_head_tag", 32'(head_tag), 32'd2);
    clear_inputs(); set_issue(2'd0, 5'd9, 32'h500, 0, 0); step();
    clear_inputs(); set_cdb(0, 2, 32'hABCD); qt[0] = 2'd2;
`ifdef ROB_CDB_BYPASS_EN
    #1;
    check("wrap_qry_ready_bypass", 32'(qry_ready[0]), 32'd1);
    check("wrap_qry_value_bypass", qry_value[0], 32'hABCD);
    step();
`else
    step();
    clear_inputs(); qt[0] = 2'd2; #1;
    check("wrap_qry_ready", 32'(qry_ready[0]), 32'd1);
    check("wrap_qry_value", qry_value[0], 32'hABCD);
`endif
    clear_inputs(); step(); step();

    // Reset while three entries are live and a commit pulse is out.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); set_issue(2'd0, 5'd3, 32'h600, 0, 0); step();
    end
    clear_inputs(); set_cdb(0, 0, 32'h55); step();
    clear_inputs(); wait_commit("rst", 4);
    rst_n = 0;
    #1;
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_commit_rd", 32'(commit_rd), 32'd0);
    check("rst_commit_value", commit_value, 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_next_tag", 32'(next_tag), 32'd0);
    do_reset();
    clear_inputs(); set_issue(2'd0, 5'd4, 32'h700, 0, 0);
    check("rst_first_tag", 32'(next_tag), 32'd0);
    step();
    check("rst_after_issue_tag", 32'(next_tag), 32'd1);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) < 5) do_reset();
      rand_inputs();
      step();
    end
    clear_inputs();
    for (int c = 0; c < 12; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
